// File: rtl/fixedpoint_square_seq.sv
// ---------------------------------------------------------------------------
// fixedpoint_square_seq
//
// Sequential squarer for unsigned fixed-point operands. An unsigned
// Q(INT_BITS).(FRAC_BITS) operand is squared exactly into an unsigned
// Q(2*INT_BITS).(2*FRAC_BITS) result. The shift-add iteration handles one
// operand bit per clock. The square is also rounded to the nearest integer,
// with halves rounding up, and the rounded value saturates at its maximum.
//
// Handshake (start / busy / done):
//   start is sampled only on an edge where the block is IDLE or DONE. On
//   such an edge the operand is captured from sq_in and the block enters
//   CALC. busy is high for exactly W cycles. done then pulses high for
//   exactly one cycle (state DONE), and the results are valid from that
//   cycle onward. A start seen during DONE begins the next operation
//   immediately. A start seen during CALC is ignored.
//
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   start    operation request
//   sq_in    unsigned Q(INT_BITS).(FRAC_BITS) operand
//   busy     high while iterating (CALC)
//   done     one-cycle completion pulse
//   sq_out   exact square, unsigned Q(2*INT_BITS).(2*FRAC_BITS)
//   n_round  sq_out rounded to nearest integer, half up, saturating
//   exact    fractional bits of sq_out are all zero
//   sat      rounding overflowed and n_round was clamped
// ---------------------------------------------------------------------------
module fixedpoint_square_seq #(
    parameter int INT_BITS  = 2,
    parameter int FRAC_BITS = 10
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    start,
    input  logic [INT_BITS+FRAC_BITS-1:0]           sq_in,
    output logic                                    busy,
    output logic                                    done,
    output logic [2*(INT_BITS+FRAC_BITS)-1:0]       sq_out,
    output logic [2*INT_BITS-1:0]                   n_round,
    output logic                                    exact,
    output logic                                    sat
);

    localparam int W     = INT_BITS + FRAC_BITS;
    localparam int OW    = 2 * W;
    localparam int IW    = 2 * INT_BITS;
    localparam int FW    = 2 * FRAC_BITS;
    localparam int CNT_W = (W > 1) ? $clog2(W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [W-1:0]      op_q, op_d;
    logic [OW-1:0]     acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [OW-1:0]     sq_q, sq_d;
    logic [IW-1:0]     n_q, n_d;
    logic              exact_q, exact_d;
    logic              sat_q, sat_d;

    // Datapath for the current iteration.
    logic [OW-1:0]     term;
    logic [OW-1:0]     acc_sum;
    logic [IW-1:0]     sum_ip;
    logic              sum_rb;
    logic              sum_frac_zero;
    logic              sum_sat;
    logic [IW-1:0]     sum_round;

    always_comb begin
        term = '0;
        if (op_q[cnt_q]) begin
            term = {{W{1'b0}}, op_q} << cnt_q;
        end
        // Never overflows: (2^W-1)^2 < 2^(2W).
        acc_sum = acc_q + term;

        // Rounding is evaluated on the running sum. Only the value at the
        // last iteration, the final square, is ever stored.
        sum_ip        = acc_sum[OW-1:FW];
        sum_rb        = acc_sum[FW-1];
        sum_frac_zero = (acc_sum[FW-1:0] == '0);
        sum_sat       = sum_rb & (&sum_ip);
        if (sum_sat) begin
            sum_round = '1;
        end else begin
            sum_round = sum_ip + IW'(sum_rb);
        end
    end

    // Next-state logic and register loads.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        sq_d    = sq_q;
        n_d     = n_q;
        exact_d = exact_q;
        sat_d   = sat_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    // The result registers are left alone here. They hold
                    // until the next completion.
                    op_d    = sq_in;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_CALC;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CALC: begin
                acc_d = acc_sum;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_DONE;
                    sq_d    = acc_sum;
                    n_d     = sum_round;
                    exact_d = sum_frac_zero;
                    sat_d   = sum_sat;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            sq_q    <= '0;
            n_q     <= '0;
            exact_q <= 1'b0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            sq_q    <= sq_d;
            n_q     <= n_d;
            exact_q <= exact_d;
            sat_q   <= sat_d;
        end
    end

    assign busy    = (state_q == ST_CALC);
    assign done    = (state_q == ST_DONE);
    assign sq_out  = sq_q;
    assign n_round = n_q;
    assign exact   = exact_q;
    assign sat     = sat_q;

endmodule

// File: tb/tb_fixedpoint_square_seq.sv
// ---------------------------------------------------------------------------
// tb_fixedpoint_square_seq
//
// Self-checking bench for fixedpoint_square_seq at its default parameters
// (Q2.10 in, Q4.20 out). The driver pushes the expected result of every
// accepted operation into exp_q. The monitor pops one entry per done pulse
// and compares it against the outputs.
// ---------------------------------------------------------------------------
module tb_fixedpoint_square_seq;

    localparam int W  = 12;
    localparam int OW = 24;
    localparam int RW = OW + 4 + 2;   // {sq_out, n_round, exact, sat}

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [W-1:0]  sq_in;
    logic          busy;
    logic          done;
    logic [OW-1:0] sq_out;
    logic [3:0]    n_round;
    logic          exact;
    logic          sat;

    fixedpoint_square_seq #(.INT_BITS(2), .FRAC_BITS(10)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .sq_in   (sq_in),
        .busy    (busy),
        .done    (done),
        .sq_out  (sq_out),
        .n_round (n_round),
        .exact   (exact),
        .sat     (sat)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    logic [RW-1:0] exp_q[$];
    int pass_cnt  = 0;
    int total_cnt = 0;
    int done_cnt  = 0;
    int busy_cnt  = 0;
    int last_done_cyc = 0;
    int start_cyc = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act !== exp) begin
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end else begin
            pass_cnt++;
        end
    endtask

    // Reference model: exact square by multiplication, then round to
    // nearest integer (half up), clamped to 15.
    function automatic logic [RW-1:0] model(input logic [W-1:0] v);
        longint unsigned sq;
        longint unsigned ip;
        longint unsigned half;
        longint unsigned frac;
        longint unsigned n;
        logic s;
        sq   = longint'(v) * longint'(v);
        ip   = sq / (64'd1 << 20);
        half = (sq / (64'd1 << 19)) % 2;
        frac = sq % (64'd1 << 20);
        n    = ip + half;
        s    = 1'b0;
        if (n > 15) begin
            n = 15;
            s = 1'b1;
        end
        return {sq[OW-1:0], n[3:0], (frac == 0), s};
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                last_done_cyc = cyc;
                check("done_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    logic [RW-1:0] e;
                    e = exp_q.pop_front();
                    check("result", 64'({sq_out, n_round, exact, sat}), 64'(e));
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_done(input int d0);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #1;
            if (done_cnt != d0) break;
        end
        check("done_timeout", 64'(done_cnt != d0), 64'd1);
    endtask

    task automatic do_op(input logic [W-1:0] v);
        int d0;
        int b0;
        @(negedge clk);
        start = 1'b1;
        sq_in = v;
        start_cyc = cyc + 1;
        exp_q.push_back(model(v));
        d0 = done_cnt;
        b0 = busy_cnt;
        @(negedge clk);
        start = 1'b0;
        sq_in = W'($urandom);
        wait_done(d0);
        check("latency", 64'(last_done_cyc - start_cyc), 64'd12);
        check("busy_cycles", 64'(busy_cnt - b0), 64'd12);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int d0;
        int code;
        rst_n = 1'b0;
        start = 1'b0;
        sq_in = '0;
        repeat (3) @(negedge clk);
        check("reset_outputs", 64'({busy, done, sq_out, n_round, exact, sat}), 64'd0);
        rst_n = 1'b1;

        // Directed values, also compared against known constants.
        do_op(12'h400);
        check("sq_1p0", 64'(sq_out), 64'h100000);
        check("n_1p0", 64'(n_round), 64'd1);
        do_op(12'h59E);
        check("sq_sqrt2", 64'(sq_out), 64'h1F8D84);
        check("n_sqrt2", 64'(n_round), 64'd2);
        do_op(12'hFFF);
        check("sq_max", 64'(sq_out), 64'hFFE001);
        check("sat_max", 64'({n_round, exact, sat}), 64'({4'd15, 1'b0, 1'b1}));
        do_op(12'h000);
        check("sq_zero", 64'({sq_out, n_round, exact}), 64'({24'd0, 4'd0, 1'b1}));

        // Square-root lookup codes must round trip to n.
        for (int n = 0; n < 16; n++) begin
            code = $rtoi($sqrt(real'(n)) * 1024.0 + 0.5);
            do_op(W'(code));
            check("lookup_n", 64'(n_round), 64'(n));
        end

        // start and sq_in during CALC must be ignored.
        @(negedge clk);
        start = 1'b1;
        sq_in = 12'h6A5;
        exp_q.push_back(model(12'h6A5));
        d0 = done_cnt;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        sq_in = 12'h95A;
        @(negedge clk);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (25) @(negedge clk);
        #1;
        check("single_done", 64'(done_cnt - d0), 64'd1);

        // Asynchronous reset in the middle of CALC.
        @(negedge clk);
        start = 1'b1;
        sq_in = 12'hABC;
        d0 = done_cnt;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_outputs", 64'({busy, done, sq_out, n_round, exact, sat}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        #1;
        check("abort_no_done", 64'(done_cnt - d0), 64'd0);
        do_op(12'h800);
        check("sq_after_abort", 64'({sq_out, n_round}), 64'({24'h400000, 4'd4}));

        // start held high: one result every 13 cycles.
        @(negedge clk);
        start = 1'b1;
        sq_in = 12'h400;
        start_cyc = cyc + 1;
        d0 = done_cnt;
        for (int k = 0; k < 3; k++) exp_q.push_back(model(12'h400));
        repeat (27) @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        #1;
        check("held_done_count", 64'(done_cnt - d0), 64'd3);
        check("held_period", 64'(last_done_cyc - start_cyc), 64'd38);

        // Randomized operands with random idle gaps.
        for (int i = 0; i < 30; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            do_op(W'($urandom));
        end

        repeat (5) @(negedge clk);
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
